// File: rtl/gmii_tx_arbiter_pkg.sv
// Shared GMII constants and arbiter FSM state encoding.
package gmii_tx_arbiter_pkg;

  localparam logic [7:0] GMII_PREAMBLE = 8'h55;
  localparam logic [7:0] GMII_SFD      = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_IFG   = 3'd4
  } state_e;

endpackage

// File: rtl/gmii_tx_arbiter_if.sv
// Byte-stream source bundle: NUM_SRC packed sources sharing one GMII TX port.
interface gmii_tx_arbiter_if #(
  parameter int NUM_SRC = 2
) ();
  import gmii_tx_arbiter_pkg::*;

  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;

  modport master (output src_data, output src_valid, output src_last, input  src_ready);
  modport slave  (input  src_data, input  src_valid, input  src_last, output src_ready);
endinterface

// File: rtl/gmii_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr_i, wrapping.
module gmii_tx_arbiter_rr_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);
  import gmii_tx_arbiter_pkg::*;

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_SRC);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    // k runs 1..NUM_SRC so the last-granted source is considered last
    for (int k = 1; k <= NUM_SRC; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= N_W) sum = sum - N_W;
      cand = sum[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

  assign any_o = found;
endmodule

// File: rtl/gmii_tx_arbiter.sv
// Frame-granular round-robin GMII TX arbiter with preamble/SFD insertion, IFG and underrun abort.
// Optional per-source counters are built when GMII_TX_ARB_STATS_EN is defined.
module gmii_tx_arbiter
  import gmii_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  gmii_tx_arbiter_if.slave       src,
  output logic [7:0]             gmii_txd,
  output logic                   gmii_tx_en,
  output logic                   gmii_tx_er,
  output logic [NUM_SRC-1:0]     grant,
  output logic [32*NUM_SRC-1:0]  stat_frames,
  output logic [16*NUM_SRC-1:0]  stat_underruns
);
  localparam int               IDX_W    = $clog2(NUM_SRC);
  localparam logic [5:0]       PRE_LAST = 6'(PREAMBLE_LEN);
  localparam logic [5:0]       IFG_LAST = 6'(IFG_BYTES);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_SRC-1);

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         txd_q, txd_d;
  logic               tx_en_q, tx_en_d;
  logic               tx_er_q, tx_er_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;

  logic [NUM_SRC-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [7:0]         data_arr [NUM_SRC];
  logic               cur_valid, cur_last;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign data_arr[gi] = src.src_data[8*gi +: 8];
  end

  // ptr_q doubles as the index of the current owner once a frame is granted
  assign cur_valid = src.src_valid[ptr_q];
  assign cur_last  = src.src_last[ptr_q];

  gmii_tx_arbiter_rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_rr (
    .req_i   (src.src_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    txd_d   = 8'h00;
    tx_en_d = 1'b0;
    tx_er_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          ptr_d   = arb_idx;
          txd_d   = GMII_PREAMBLE;
          tx_en_d = 1'b1;
          cnt_d   = 6'd1;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q < PRE_LAST) begin
          txd_d = GMII_PREAMBLE;
          cnt_d = cnt_q + 6'd1;
        end else begin
          txd_d   = GMII_SFD;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_en_d = 1'b1;
        if (cur_valid) begin
          txd_d = data_arr[ptr_q];
          if (cur_last) begin
            state_d = ST_IFG;
            cnt_d   = 6'd0;
            grant_d = '0;
          end
        end else begin
          tx_er_d = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cur_valid && cur_last) begin
          state_d = ST_IFG;
          cnt_d   = 6'd0;
          grant_d = '0;
        end
      end
      ST_IFG: begin
        if (cnt_q == IFG_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 6'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_RST;
      txd_q   <= '0;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      tx_er_q <= tx_er_d;
      grant_q <= grant_d;
    end
  end

  assign src.src_ready = (state_q == ST_DATA || state_q == ST_DRAIN) ? grant_q : '0;
  assign gmii_txd      = txd_q;
  assign gmii_tx_en    = tx_en_q;
  assign gmii_tx_er    = tx_er_q;
  assign grant         = grant_q;

`ifdef GMII_TX_ARB_STATS_EN
  logic [31:0] frames_q [NUM_SRC];
  logic [31:0] frames_d [NUM_SRC];
  logic [15:0] under_q  [NUM_SRC];
  logic [15:0] under_d  [NUM_SRC];
  logic        frame_done, underrun;

  assign frame_done = (state_q == ST_DATA) && cur_valid && cur_last;
  assign underrun   = (state_q == ST_DATA) && !cur_valid;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      frames_d[i] = frames_q[i];
      under_d[i]  = under_q[i];
      if (ptr_q == IDX_W'(i)) begin
        if (frame_done) frames_d[i] = frames_q[i] + 32'd1;
        if (underrun)   under_d[i]  = under_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sys_rst) begin
        frames_q[i] <= '0;
        under_q[i]  <= '0;
      end else begin
        frames_q[i] <= frames_d[i];
        under_q[i]  <= under_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_stats
    assign stat_frames[32*gi +: 32]    = frames_q[gi];
    assign stat_underruns[16*gi +: 16] = under_q[gi];
  end
`else
  assign stat_frames    = '0;
  assign stat_underruns = '0;
`endif
endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: cycle tables for single frames/underrun, sequences for reset and back-to-back.
module tb_gmii_tx_arbiter;
  localparam int N   = 2;
  localparam int IFG = 12;
`ifdef GMII_TX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en, gmii_tx_er;
  logic [N-1:0] grant;
  logic [63:0] stat_frames;
  logic [31:0] stat_underruns;

  always #4 sys_clk = ~sys_clk;

  gmii_tx_arbiter_if #(.NUM_SRC(N)) sif ();

  gmii_tx_arbiter #(.NUM_SRC(N), .PREAMBLE_LEN(7), .IFG_BYTES(IFG)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .src            (sif),
    .gmii_txd       (gmii_txd),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_tx_er     (gmii_tx_er),
    .grant          (grant),
    .stat_frames    (stat_frames),
    .stat_underruns (stat_underruns)
  );

  typedef struct {
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] txd;
    logic       en;
    logic       er;
    logic [1:0] rdy;
    logic [1:0] gnt;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sif.src_valid = '0;
    sif.src_last  = '0;
    sif.src_data  = '0;
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  task automatic add(input logic [1:0] v, input logic [1:0] l, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [7:0] txd, input logic en, input logic er, input logic [1:0] rdy,
                     input logic [1:0] gnt);
    vec_t r;
    r.v = v; r.l = l; r.d0 = d0; r.d1 = d1;
    r.txd = txd; r.en = en; r.er = er; r.rdy = rdy; r.gnt = gnt;
    tbl.push_back(r);
  endtask

  // Each row: apply inputs for this cycle, check outputs as they stand now, then clock.
  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      sif.src_valid = tbl[i].v;
      sif.src_last  = tbl[i].l;
      sif.src_data  = {tbl[i].d1, tbl[i].d0};
      #1;
      $display("%s row %0d: txd=%h en=%b er=%b rdy=%b gnt=%b", name, i, gmii_txd, gmii_tx_en,
               gmii_tx_er, sif.src_ready, grant);
      chk({name, "_txd"},   i, 64'(gmii_txd),      64'(tbl[i].txd));
      chk({name, "_en"},    i, 64'(gmii_tx_en),    64'(tbl[i].en));
      chk({name, "_er"},    i, 64'(gmii_tx_er),    64'(tbl[i].er));
      chk({name, "_ready"}, i, 64'(sif.src_ready), 64'(tbl[i].rdy));
      chk({name, "_grant"}, i, 64'(grant),         64'(tbl[i].gnt));
      step();
    end
    tbl.delete();
  endtask

  function automatic logic [7:0] sbyte(input int s, input int fr, input int b);
    return 8'((s << 7) | (fr << 4) | b);
  endfunction

  // Back-to-back scenario: src0 sends 3 frames of 4 bytes, src1 one frame of 3 bytes, both valid from reset.
  task automatic run_scenario();
    int nfr[2]   = '{3, 1};
    int len[2]   = '{4, 3};
    int order[4] = '{0, 1, 0, 0};
    int f[2]     = '{0, 0};
    int k[2]     = '{0, 0};
    int fdone[2] = '{0, 0};
    logic [1:0] rdy_prev;
    logic [7:0] exp_b;
    logic in_frame = 1'b0;
    int pos = 0, gap = 0, fc = 0, cur = 0, cyc = 0;
    for (int i = 0; i < 2; i++) begin
      sif.src_valid[i]       = 1'b1;
      sif.src_last[i]        = (len[i] == 1);
      sif.src_data[8*i +: 8] = sbyte(i, 0, 0);
    end
    rdy_prev = sif.src_ready;
    while (fc < 4 && cyc < 2000) begin
      step();
      cyc++;
      if (gmii_tx_en) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          pos = 0;
          cur = order[fc];
          if (fc > 0) chk("b2b_gap", fc, 64'(gap), 64'(IFG + 1));
          chk("b2b_grant", fc, 64'(grant), 64'(1 << cur));
        end
        exp_b = (pos < 7) ? 8'h55 : (pos == 7) ? 8'hD5 : sbyte(cur, fdone[cur], pos - 8);
        chk("b2b_txd", fc, 64'(gmii_txd), 64'(exp_b));
        chk("b2b_er",  fc, 64'(gmii_tx_er), 64'd0);
        if (pos < 7) chk("b2b_rdy_pre", fc, 64'(sif.src_ready), 64'd0);
        else         chk("b2b_rdy_own", fc, 64'(sif.src_ready & ~grant), 64'd0);
        pos++;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          $display("b2b frame %0d: src=%0d bytes=%0d gap_before=%0d", fc, cur, pos, gap);
          chk("b2b_flen", fc, 64'(pos), 64'(8 + len[cur]));
          fdone[cur]++;
          fc++;
          gap = 0;
        end
        gap++;
        chk("b2b_rdy_idle", fc, 64'(sif.src_ready), 64'd0);
      end
      for (int i = 0; i < 2; i++) begin
        if (sif.src_valid[i] && rdy_prev[i]) begin
          k[i]++;
          if (k[i] == len[i]) begin
            k[i] = 0;
            f[i]++;
          end
        end
        sif.src_valid[i]       = (f[i] < nfr[i]);
        sif.src_last[i]        = (k[i] == len[i] - 1);
        sif.src_data[8*i +: 8] = sbyte(i, f[i], k[i]);
      end
      rdy_prev = sif.src_ready;
    end
    chk("b2b_frames_seen", 0, 64'(fc), 64'd4);
    sif.src_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sif.src_valid = '0;
    sif.src_last  = '0;
    sif.src_data  = '0;

    // Reset state
    do_reset();
    #1;
    $display("reset: txd=%h en=%b er=%b gnt=%b rdy=%b", gmii_txd, gmii_tx_en, gmii_tx_er, grant, sif.src_ready);
    chk("rst_txd",   0, 64'(gmii_txd), 64'd0);
    chk("rst_en",    0, 64'(gmii_tx_en), 64'd0);
    chk("rst_er",    0, 64'(gmii_tx_er), 64'd0);
    chk("rst_grant", 0, 64'(grant), 64'd0);
    chk("rst_ready", 0, 64'(sif.src_ready), 64'd0);
    chk("rst_stats", 0, stat_frames | 64'(stat_underruns), 64'd0);

    // Single 4-byte frame on src0
    add(2'b01, 2'b00, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 7; i++) add(2'b01, 2'b00, 8'h11, 8'h00, 8'h55, 1'b1, 1'b0, 2'b00, 2'b01);
    add(2'b01, 2'b00, 8'h11, 8'h00, 8'hD5, 1'b1, 1'b0, 2'b01, 2'b01);
    add(2'b01, 2'b00, 8'h22, 8'h00, 8'h11, 1'b1, 1'b0, 2'b01, 2'b01);
    add(2'b01, 2'b00, 8'h33, 8'h00, 8'h22, 1'b1, 1'b0, 2'b01, 2'b01);
    add(2'b01, 2'b01, 8'h44, 8'h00, 8'h33, 1'b1, 1'b0, 2'b01, 2'b01);
    add(2'b00, 2'b00, 8'h00, 8'h00, 8'h44, 1'b1, 1'b0, 2'b00, 2'b00);
    add(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    add(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    run_table("t1");

    // Underrun on src1 after two bytes, remaining three drained
    do_reset();
    add(2'b10, 2'b00, 8'h00, 8'hA1, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 7; i++) add(2'b10, 2'b00, 8'h00, 8'hA1, 8'h55, 1'b1, 1'b0, 2'b00, 2'b10);
    add(2'b10, 2'b00, 8'h00, 8'hA1, 8'hD5, 1'b1, 1'b0, 2'b10, 2'b10);
    add(2'b10, 2'b00, 8'h00, 8'hA2, 8'hA1, 1'b1, 1'b0, 2'b10, 2'b10);
    add(2'b00, 2'b00, 8'h00, 8'h00, 8'hA2, 1'b1, 1'b0, 2'b10, 2'b10);
    add(2'b10, 2'b00, 8'h00, 8'hA3, 8'h00, 1'b1, 1'b1, 2'b10, 2'b10);
    add(2'b10, 2'b00, 8'h00, 8'hA4, 8'h00, 1'b0, 1'b0, 2'b10, 2'b10);
    add(2'b10, 2'b10, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0, 2'b10, 2'b10);
    add(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00);
    run_table("t3");
    $display("t3 stats: frames=%h underruns=%h", stat_frames, stat_underruns);
    chk("t3_stat_underruns", 0, 64'(stat_underruns), STATS ? 64'h0001_0000 : 64'd0);
    chk("t3_stat_frames",    0, stat_frames, 64'd0);

    // Reset in the middle of DATA, then both sources request: src0 must win again
    do_reset();
    sif.src_valid = 2'b01;
    sif.src_data  = 16'h0077;
    for (int t = 0; t < 20 && sif.src_ready[0] !== 1'b1; t++) step();
    chk("t4_reach_data", 0, 64'(sif.src_ready), 64'd1);
    step();
    step();
    chk("t4_mid_en", 0, 64'(gmii_tx_en), 64'd1);
    sys_rst = 1'b1;
    step();
    $display("t4 after reset edge: txd=%h en=%b er=%b gnt=%b", gmii_txd, gmii_tx_en, gmii_tx_er, grant);
    chk("t4_rst_en",    0, 64'(gmii_tx_en), 64'd0);
    chk("t4_rst_grant", 0, 64'(grant), 64'd0);
    chk("t4_rst_txd",   0, 64'(gmii_txd), 64'd0);
    chk("t4_rst_ready", 0, 64'(sif.src_ready), 64'd0);
    sys_rst = 1'b0;
    sif.src_valid = 2'b11;
    step();
    $display("t4 re-arbitration: txd=%h en=%b gnt=%b", gmii_txd, gmii_tx_en, grant);
    chk("t4_rearb_grant", 0, 64'(grant), 64'd1);
    chk("t4_rearb_txd",   0, 64'(gmii_txd), 64'h55);

    // Back-to-back frames, fairness, IFG spacing and statistics
    do_reset();
    run_scenario();
    step();
    $display("b2b stats: frames=%h underruns=%h", stat_frames, stat_underruns);
    chk("b2b_stat_frames",    0, stat_frames, STATS ? {32'd1, 32'd3} : 64'd0);
    chk("b2b_stat_underruns", 0, 64'(stat_underruns), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
